program_loader: RTL
===================

// Module: program_loader
// PURPOSE
//  Upstream of instruction fetch. Receives a byte stream (e.g. the DE2-115 UART receiver) and
//  packs it into 32-bit words written into instruction memory. Holds the CPU in reset while
//  loading; releases it once a complete, valid image is stored.
// PARAMETERS
//  MEM_DEPTH   256  instruction memory depth in words; maximum accepted image length
//  ADDR_WIDTH  8    word-address width; must equal clog2(MEM_DEPTH)
// PORTS
//  clk          in   1           system clock; all logic on rising edge
//  reset        in   1           synchronous, active-high
//  byteValid    in   1           byteData carries a valid byte
//  byteData     in   8           stream byte
//  byteReady    out  1           loader accepts a byte this cycle
//  restartLoad  in   1           one-cycle pulse: reload a new image from DONE/ERROR
//  wordWrite    out  1           one-cycle instruction-memory write strobe
//  wordAddr     out  ADDR_WIDTH  write word address
//  wordData     out  32          write data
//  cpuReset     out  1           reset to the CPU stages; high while not DONE
//  loadDone     out  1           image stored; CPU released
//  loadError    out  1           image rejected
// BEHAVIOUR
//  - Handshake: byte accepted on cycle where byteValid && byteReady. byteReady=1 only in
//    COUNT_LO, COUNT_HI, WORD and CHECK; byteReady=0 in DONE/ERROR. byteData ignored otherwise.
//  - Reset values: state=COUNT_LO, byteReady=1, wordWrite=0, wordAddr=0, wordData=0,
//    cpuReset=1, loadDone=0, loadError=0. Internal counters and partial word cleared.
//  - Frame: 2-byte little-endian word count N, then N words, each 4 bytes little-endian
//    (first byte -> [7:0]), then (CHECKSUM_EN only) one check byte.
//  - FSM:
//    - COUNT_LO: accept byte -> COUNT_HI.
//    - COUNT_HI: accept byte. Next state:
//      - N > MEM_DEPTH -> ERROR.
//      - N == 0 -> CHECK (if CHECKSUM_EN) else DONE.
//      - else -> WORD.
//    - WORD: byte index 0..3 wraps. On the 4th accepted byte, the next cycle has wordWrite=1,
//      wordData=packed word, wordAddr=word index (0, 1, ...). Write latency is exactly 1 cycle.
//      Bytes continue to be accepted on that cycle (no bubble required). After word N-1 is
//      written -> CHECK/DONE.
//    - CHECK: accept byte. Equal to running check -> DONE, else -> ERROR.
//    - DONE: cpuReset=0, loadDone=1.
//    - ERROR: cpuReset=1, loadError=1.
//  - restartLoad in DONE/ERROR: next cycle state=COUNT_LO, cpuReset=1, loadDone=loadError=0,
//    counters cleared. restartLoad in any other state is ignored.
//  - Reset mid-frame: partial word discarded, no write issued; the next byte is treated as COUNT_LO.
//  - The word index never exceeds N-1 <= MEM_DEPTH-1, so wordAddr never wraps.
//  - cpuReset is registered. It deasserts the cycle after DONE is entered, never earlier than the
//    last wordWrite.
// CONFIGURATION
//  CHECKSUM_EN defined: running XOR of all word bytes (header excluded, initial value 0x00). CHECK
//    state present; a mismatch -> ERROR.
//  CHECKSUM_EN undefined: no CHECK state. The frame ends after the last word; loadError only from
//    N > MEM_DEPTH.
// STRUCTURE
//  - loader_pkg: loader_state_t enum {COUNT_LO, COUNT_HI, WORD, CHECK, DONE, ERROR}; localparam
//    WORD_BYTES=4.
//  - Sub-module byte_packer: 2-bit byte index plus 32-bit shift/insert register. Outputs
//    wordReadyPulse and packed word. Cleared by reset or restart.
// TESTING
//  1. Reset, then bytes 02 00 | 13 00 00 20 | 08 00 00 00 -> writes (0, 0x20000013) and
//     (1, 0x00000008); loadDone=1; cpuReset falls after the 2nd write.
//  2. Header 01 01 (N=257 > 256) -> loadError=1, byteReady=0, no wordWrite, cpuReset stays 1.
//  3. Header 00 00 -> DONE with no writes (CHECKSUM_EN: the next byte 00 -> DONE, 01 -> ERROR).
//  4. CHECKSUM_EN: N=1, word bytes AA 55 0F F0, check byte 00 -> DONE; check byte 01 -> ERROR.
//  5. byteValid toggled randomly (gaps), N=3 -> identical writes, each exactly 1 cycle after its
//     4th byte.
//  6. reset asserted after 2 bytes of word 0, then a full N=1 frame -> single write to addr 0 with
//     new data. Then restartLoad from DONE with N=1 -> cpuReset rises, addr 0 rewritten, DONE again.

Source files
------------

// File: rtl/loader_pkg.sv
// +--------------------------------------------------------------------------+
// | Module  : loader_pkg                                                     |
// | Brief   : Shared state encoding and frame constants for program_loader.  |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

package loader_pkg;

  typedef enum logic [2:0] {
    COUNT_LO = 3'd0,
    COUNT_HI = 3'd1,
    WORD     = 3'd2,
    CHECK    = 3'd3,
    DONE     = 3'd4,
    ERROR    = 3'd5
  } loader_state_t;

  localparam int WORD_BYTES  = 4;
  localparam int COUNT_WIDTH = 16;

endpackage

`default_nettype wire

// File: rtl/byte_packer.sv
// +--------------------------------------------------------------------------+
// | Module  : byte_packer                                                    |
// | Brief   : Packs little-endian bytes into 32-bit words, pulses when full. |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        last_lane_o,
  output logic        word_ready_pulse_o,
  output logic [31:0] word_o
);

  logic [1:0]  idx_q,   idx_d;
  logic [31:0] word_q,  word_d;
  logic        pulse_q, pulse_d;

  assign last_lane_o = (idx_q == 2'(WORD_BYTES - 1));

  // Lanes are overwritten in place, so the register holds the full word for
  // exactly the cycle after its last byte, even if the next byte lands then.
  always_comb begin
    idx_d   = idx_q;
    word_d  = word_q;
    pulse_d = 1'b0;
    if (byte_valid_i) begin
      word_d[{idx_q, 3'b000} +: 8] = byte_data_i;
      idx_d   = idx_q + 2'd1;
      pulse_d = last_lane_o;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      idx_q   <= 2'd0;
      word_q  <= 32'd0;
      pulse_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      word_q  <= word_d;
      pulse_q <= pulse_d;
    end
  end

  assign word_ready_pulse_o = pulse_q;
  assign word_o             = word_q;

endmodule

`default_nettype wire

// File: rtl/program_loader.sv
// +--------------------------------------------------------------------------+
// | Module  : program_loader                                                 |
// | Brief   : Loads a counted byte-stream image into instruction memory and  |
// |           holds the CPU in reset until the image is complete.            |
// | Build   : define CHECKSUM_EN to add the trailing XOR check byte.         |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module program_loader
  import loader_pkg::*;
#(
  parameter int MEM_DEPTH  = 256,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  byteValid,
  input  logic [7:0]            byteData,
  output logic                  byteReady,
  input  logic                  restartLoad,
  output logic                  wordWrite,
  output logic [ADDR_WIDTH-1:0] wordAddr,
  output logic [31:0]           wordData,
  output logic                  cpuReset,
  output logic                  loadDone,
  output logic                  loadError
);

  localparam logic [COUNT_WIDTH-1:0] c_max_words = COUNT_WIDTH'(MEM_DEPTH);
`ifdef CHECKSUM_EN
  localparam loader_state_t c_frame_end = CHECK;
`else
  localparam loader_state_t c_frame_end = DONE;
`endif

  loader_state_t          state_q,    state_d;
  logic [COUNT_WIDTH-1:0] count_q,    count_d;
  logic [ADDR_WIDTH-1:0]  word_idx_q, word_idx_d;
  logic [ADDR_WIDTH-1:0]  addr_q,     addr_d;
  logic                   cpu_rst_q,  cpu_rst_d;
`ifdef CHECKSUM_EN
  logic [7:0]             chk_q,      chk_d;
`endif

  logic                   accept;
  logic                   word_byte;
  logic                   restart_ok;
  logic                   last_lane;
  logic [COUNT_WIDTH-1:0] hdr_count;

  assign byteReady  = (state_q == COUNT_LO) || (state_q == COUNT_HI) ||
                      (state_q == WORD)     || (state_q == CHECK);
  assign accept     = byteValid && byteReady;
  assign word_byte  = accept && (state_q == WORD);
  assign restart_ok = restartLoad && ((state_q == DONE) || (state_q == ERROR));
  assign hdr_count  = {byteData, count_q[7:0]};

  byte_packer u_packer (
    .clk                (clk),
    .reset              (reset),
    .clear_i            (restart_ok),
    .byte_valid_i       (word_byte),
    .byte_data_i        (byteData),
    .last_lane_o        (last_lane),
    .word_ready_pulse_o (wordWrite),
    .word_o             (wordData)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;
    addr_d     = addr_q;
`ifdef CHECKSUM_EN
    chk_d      = chk_q;
`endif
    case (state_q)
      COUNT_LO: begin
        if (accept) begin
          count_d[7:0] = byteData;
          state_d      = COUNT_HI;
        end
      end
      COUNT_HI: begin
        if (accept) begin
          count_d = hdr_count;
          if (hdr_count > c_max_words) begin
            state_d = ERROR;
          end else if (hdr_count == '0) begin
            state_d = c_frame_end;
          end else begin
            state_d = WORD;
          end
        end
      end
      WORD: begin
        if (accept) begin
`ifdef CHECKSUM_EN
          chk_d = chk_q ^ byteData;
`endif
          if (last_lane) begin
            // Address is latched with the word so it lines up with the write strobe.
            addr_d     = word_idx_q;
            word_idx_d = word_idx_q + 1'b1;
            if (COUNT_WIDTH'(word_idx_q) == count_q - 1'b1) begin
              state_d = c_frame_end;
            end
          end
        end
      end
`ifdef CHECKSUM_EN
      CHECK: begin
        if (accept) begin
          state_d = (byteData == chk_q) ? DONE : ERROR;
        end
      end
`endif
      DONE, ERROR: begin
        if (restartLoad) begin
          state_d    = COUNT_LO;
          count_d    = '0;
          word_idx_d = '0;
          addr_d     = '0;
`ifdef CHECKSUM_EN
          chk_d      = '0;
`endif
        end
      end
      default: state_d = COUNT_LO;
    endcase
  end

  // Released only once DONE has been registered, so never before the last write.
  assign cpu_rst_d = !((state_q == DONE) && !restartLoad);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= COUNT_LO;
      count_q    <= '0;
      word_idx_q <= '0;
      addr_q     <= '0;
      cpu_rst_q  <= 1'b1;
`ifdef CHECKSUM_EN
      chk_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      word_idx_q <= word_idx_d;
      addr_q     <= addr_d;
      cpu_rst_q  <= cpu_rst_d;
`ifdef CHECKSUM_EN
      chk_q      <= chk_d;
`endif
    end
  end

  assign wordAddr  = addr_q;
  assign cpuReset  = cpu_rst_q;
  assign loadDone  = (state_q == DONE);
  assign loadError = (state_q == ERROR);

endmodule

`default_nettype wire
